data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised, handshaked data memory for the RISC-V core's load/store path.
- Adds the following to the fixed 64-word single-cycle data memory:
  - configurable depth and wait states;
  - valid/ready request and response channels;
  - funct3-coded access sizes with sign/zero extension;
  - misalignment, out-of-range and illegal-size fault reporting.
- Sits between the load/store unit and on-chip data RAM. It is the basis for multi-cycle and pipelined core variants.

Parameters:
- ADDR_W, 32: request address width in bits.
- DEPTH, 64: memory depth in 32-bit words. Must be a power of two, at least 4.
- WAIT_STATES, 1: extra cycles between request acceptance and the access commit. Range 0..15.

Ports:
- clk  in  1  clock. All state updates on its rising edge.
- reset  in  1  synchronous reset, active-low (asserted when 0). Sampled on the rising edge of clk.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  byte address.
- req_size  in  3  funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended to 32 bits. 0 for stores and faults.
- rsp_err  out  1  access fault. No memory side effect when set.

Behaviour:
- Reset (reset==0 at a clk edge):
  - FSM goes to IDLE; wait counter cleared.
  - Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
  - All DEPTH words cleared to 0.
  - Reset overrides every other event in the same cycle.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - A request is accepted on an edge with req_valid && req_ready.
  - At acceptance the block latches we, addr, size and wdata, and the fault checks below are evaluated.
  - If WAIT_STATES==0, next state is RESP. Otherwise next state is WAIT with the counter set to WAIT_STATES-1.
- WAIT:
  - req_ready=0.
  - The counter decrements each cycle. When it reaches 0, next state is RESP.
- Commit (on the edge entering RESP):
  - Stores write only the addressed byte lanes.
  - Loads capture rsp_rdata.
  - Faulted requests do no access and respond with rsp_err=1, rsp_rdata=0.
- Latency: request accepted at edge N; rsp_valid=1 from edge N+WAIT_STATES+1.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata and rsp_err are held stable while rsp_ready=0.
  - On an edge with rsp_ready=1, go to IDLE and drop rsp_valid.
  - There is no zero-bubble back-to-back: the next request can be accepted one cycle after the response handshake.
- Fault checks (any one sets the fault):
  - size H/HU with addr[0]!=0;
  - size W with addr[1:0]!=0;
  - word index addr[ADDR_W-1:2] >= DEPTH;
  - size 011, 110 or 111;
  - store with size 100 or 101.
- Store lane mapping:
  - B writes wdata[7:0] to byte lane addr[1:0].
  - H writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - W writes all four lanes.
  - Unaddressed lanes are unchanged.
- Load extraction:
  - Select the byte or half at the lane given by addr[1:0] or addr[1].
  - B and H sign-extend from the top bit of the selected field. BU and HU zero-extend. W passes the word through.
- Reset mid-operation (in WAIT or RESP):
  - A pending store is discarded if not yet committed.
  - Memory is cleared regardless.
  - rsp_valid is 0 from the reset edge onward.
- req_valid in WAIT or RESP is ignored (req_ready=0). The requester must hold the request until it is accepted.

Test Plan (DEPTH=64, WAIT_STATES=2):
- SW addr 0x10 wdata 0x800080F0, then LW 0x10 -> each rsp_valid 3 cycles after acceptance, rsp_err=0; load returns 0x800080F0.
- After the above: SB addr 0x12 wdata 0x000000A5, then LW 0x10 -> 0x80A580F0. Then:
  - LB 0x12 -> 0xFFFFFFA5;
  - LBU 0x12 -> 0x000000A5;
  - LH 0x12 -> 0xFFFF80A5.
- Fault cases, each with rsp_err=1 and rsp_rdata=0:
  - LH addr 0x13: LW 0x10 afterwards still returns 0x80A580F0.
  - SW addr 0x100 (word 64): no write.
  - Store with size 100: no write.
- Backpressure: LW 0x10 with rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata=0x80A580F0 stable throughout. req_valid pulses meanwhile are not accepted. rsp_ready=1 -> IDLE next edge.
- Reset mid-WAIT: SW 0x20 wdata 0x12345678, then reset=0 for 1 cycle after acceptance -> rsp_valid never asserts. LW 0x20 -> 0x00000000, and LW 0x10 -> 0x00000000 (memory cleared).
- WAIT_STATES=0 build: LW accepted at edge N -> rsp_valid at edge N+1. With rsp_ready=1, req_ready=1 again at N+2.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Handshaked data memory for the load/store path: valid/ready request and response,
// configurable wait states, funct3 access sizes, and fault reporting with no side effects.
module data_memory_ctrl #(
    parameter int ADDR_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [2:0]        req_size,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        size_q, size_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];

    logic              commit;
    logic              cur_we, cur_fault;
    logic [ADDR_W-1:0] cur_addr;
    logic [2:0]        cur_size;
    logic [31:0]       cur_wdata, wr_data;
    logic [3:0]        wr_be;
    logic [IDX_W-1:0]  cur_idx;

    function automatic logic is_fault(input logic we, input logic [ADDR_W-1:0] addr,
                                      input logic [2:0] size);
        logic f;
        f = (addr >> (IDX_W + 2)) != '0;
        case (size)
            3'b000, 3'b100: ;
            3'b001, 3'b101: f = f | addr[0];
            3'b010:         f = f | (addr[1:0] != 2'b00);
            default:        f = 1'b1;
        endcase
        if (we && size[2]) f = 1'b1;
        return f;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] lane,
                                             input logic [2:0] size);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[8*lane +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        case (size)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return w;
            3'b100:  return {24'b0, b};
            3'b101:  return {16'b0, h};
            default: return '0;
        endcase
    endfunction

    // In IDLE the access comes straight off the request bus (zero-wait commit); later from the latch.
    assign cur_we    = (state_q == IDLE) ? req_we    : we_q;
    assign cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
    assign cur_size  = (state_q == IDLE) ? req_size  : size_q;
    assign cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
    assign cur_fault = is_fault(cur_we, cur_addr, cur_size);
    assign cur_idx   = cur_addr[IDX_W+1:2];

    always_comb begin
        wr_be   = 4'b0000;
        wr_data = cur_wdata;
        case (cur_size[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << cur_addr[1:0];
                wr_data = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = cur_addr[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cur_wdata[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: wr_be = 4'b0000;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        size_d      = size_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        commit      = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                we_d    = req_we;
                addr_d  = req_addr;
                size_d  = req_size;
                wdata_d = req_wdata;
                if (WAIT_STATES == 0) begin
                    state_d = RESP;
                    commit  = 1'b1;
                end else begin
                    state_d = WAIT;
                    cnt_d   = 4'(WAIT_STATES - 1);
                end
            end
            WAIT: if (cnt_q == 4'd0) begin
                state_d = RESP;
                commit  = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (commit) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = cur_fault;
            rsp_rdata_d = (cur_fault || cur_we) ? '0 : load_ext(mem_q[cur_idx], cur_addr[1:0], cur_size);
            if (!cur_fault && cur_we) begin
                for (int b = 0; b < 4; b++)
                    if (wr_be[b]) mem_d[cur_idx][8*b +: 8] = wr_data[8*b +: 8];
            end
        end

        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            size_q      <= '0;
            wdata_q     <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            wdata_q     <= wdata_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: a WAIT_STATES=2 instance driven through directed
// accesses with a negedge monitor, plus a WAIT_STATES=0 instance for the zero-wait timing.
module tb_data_memory_ctrl;
    localparam int WS = 2;
    localparam logic [2:0] SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010, SZ_BU = 3'b100, SZ_HU = 3'b101;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        z_req_valid, z_req_ready, z_req_we;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [2:0]  z_req_size;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    data_memory_ctrl #(.ADDR_W(32), .DEPTH(64), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    data_memory_ctrl #(.ADDR_W(32), .DEPTH(64), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
        .req_addr(z_req_addr), .req_size(z_req_size), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, acc_cyc = 0;
    bit   rsp_seen = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: attributes each negedge sample to the next rising edge.
    initial forever begin
        @(negedge clk);
        if (reset && req_valid && req_ready) acc_cyc = cyc + 1;
        if (rsp_valid) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rsp: rsp_valid=1 rdata=0x%08h with nothing outstanding", rsp_rdata);
            end else begin
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    chk({sb[0].name, " latency"}, 32'(cyc + 1 - acc_cyc), 32'(WS + 1));
                end
                chk({sb[0].name, " req_ready_low"}, 32'(req_ready), 32'd0);
                if (rsp_ready) begin
                    chk({sb[0].name, " rdata"}, rsp_rdata, sb[0].rdata);
                    chk({sb[0].name, " err"}, 32'(rsp_err), 32'(sb[0].err));
                    void'(sb.pop_front());
                    rsp_seen = 1'b0;
                end else begin
                    chk({sb[0].name, " held_rdata"}, rsp_rdata, sb[0].rdata);
                end
            end
        end
    end

    task automatic issue(input string name, input logic we, input logic [31:0] addr,
                         input logic [2:0] size, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err, input bit expect_rsp);
        exp_t e;
        int   t;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        e.name  = name;
        if (expect_rsp) sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size; req_wdata = wdata;
        t = 0;
        while (!req_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) timeout({name, " accept"});
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int t;
        t = 0;
        while (sb.size() != 0 && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (sb.size() != 0) begin
            timeout({name, " response"});
            sb.delete();
        end
    endtask

    task automatic access(input string name, input logic we, input logic [31:0] addr,
                          input logic [2:0] size, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input logic exp_err);
        issue(name, we, addr, size, wdata, exp_rdata, exp_err, 1'b1);
        wait_rsp(name);
    endtask

    // Zero-wait instance: accepted at edge N, response visible at N+1, ready again at N+2.
    task automatic z_access(input string name, input logic we, input logic [31:0] addr,
                            input logic [2:0] size, input logic [31:0] wdata, input logic [31:0] exp_rdata);
        @(posedge clk); #1;
        z_req_valid = 1'b1; z_req_we = we; z_req_addr = addr; z_req_size = size; z_req_wdata = wdata;
        chk({name, " ready_before"}, 32'(z_req_ready), 32'd1);
        @(posedge clk); #1;
        z_req_valid = 1'b0;
        chk({name, " rsp_valid_n1"}, 32'(z_rsp_valid), 32'd1);
        chk({name, " req_ready_n1"}, 32'(z_req_ready), 32'd0);
        chk({name, " rdata"}, z_rsp_rdata, exp_rdata);
        chk({name, " err"}, 32'(z_rsp_err), 32'd0);
        @(posedge clk); #1;
        chk({name, " rsp_valid_n2"}, 32'(z_rsp_valid), 32'd0);
        chk({name, " req_ready_n2"}, 32'(z_req_ready), 32'd1);
    endtask

    initial begin
        int t;
        reset = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = '0; req_wdata = '0; rsp_ready = 1'b1;
        z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_size = '0; z_req_wdata = '0; z_rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset req_ready", 32'(req_ready), 32'd0);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b1;
        repeat (2) @(posedge clk);

        access("sw_10",  1'b1, 32'h10, SZ_W,  32'h800080F0, 32'h0,        1'b0);
        access("lw_10a", 1'b0, 32'h10, SZ_W,  32'h0,        32'h800080F0, 1'b0);
        access("sb_12",  1'b1, 32'h12, SZ_B,  32'h000000A5, 32'h0,        1'b0);
        access("lw_10b", 1'b0, 32'h10, SZ_W,  32'h0,        32'h80A580F0, 1'b0);
        access("lb_12",  1'b0, 32'h12, SZ_B,  32'h0,        32'hFFFFFFA5, 1'b0);
        access("lbu_12", 1'b0, 32'h12, SZ_BU, 32'h0,        32'h000000A5, 1'b0);
        access("lh_12",  1'b0, 32'h12, SZ_H,  32'h0,        32'hFFFF80A5, 1'b0);
        access("lh_10",  1'b0, 32'h10, SZ_H,  32'h0,        32'hFFFF80F0, 1'b0);
        access("lhu_10", 1'b0, 32'h10, SZ_HU, 32'h0,        32'h000080F0, 1'b0);
        access("lb_11",  1'b0, 32'h11, SZ_B,  32'h0,        32'hFFFFFF80, 1'b0);

        access("lh_13_mis",   1'b0, 32'h13,  SZ_H,   32'h0,        32'h0, 1'b1);
        access("lw_11_mis",   1'b0, 32'h11,  SZ_W,   32'h0,        32'h0, 1'b1);
        access("sw_100_oor",  1'b1, 32'h100, SZ_W,   32'h5555AAAA, 32'h0, 1'b1);
        access("sbu_10_ill",  1'b1, 32'h10,  SZ_BU,  32'h11111111, 32'h0, 1'b1);
        access("ld_sz3_ill",  1'b0, 32'h10,  3'b011, 32'h0,        32'h0, 1'b1);
        access("lw_10_after", 1'b0, 32'h10,  SZ_W,   32'h0,        32'h80A580F0, 1'b0);
        access("lw_000_wrap", 1'b0, 32'h0,   SZ_W,   32'h0,        32'h0, 1'b0);
        access("sw_fc_top",   1'b1, 32'hFC,  SZ_W,   32'hCAFEF00D, 32'h0, 1'b0);
        access("lw_fc_top",   1'b0, 32'hFC,  SZ_W,   32'h0,        32'hCAFEF00D, 1'b0);

        // Backpressure: hold rsp_ready low while req_valid pulses must be ignored.
        rsp_ready = 1'b0;
        issue("lw_bp", 1'b0, 32'h10, SZ_W, 32'h0, 32'h80A580F0, 1'b0, 1'b1);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (!rsp_valid) timeout("lw_bp rsp_valid");
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0];
            req_we = 1'b1; req_addr = 32'h10; req_size = SZ_W; req_wdata = 32'hDEADDEAD;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp rsp_valid_dropped", 32'(rsp_valid), 32'd0);
        chk("bp req_ready_back", 32'(req_ready), 32'd1);
        wait_rsp("lw_bp");
        access("lw_10_post_bp", 1'b0, 32'h10, SZ_W, 32'h0, 32'h80A580F0, 1'b0);

        // Reset in WAIT: pending store dropped, no response, memory cleared.
        issue("sw_20_rst", 1'b1, 32'h20, SZ_W, 32'h12345678, 32'h0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("rst_wait rsp_valid", 32'(rsp_valid), 32'd0);
            @(posedge clk); #1;
        end
        access("lw_20_cleared", 1'b0, 32'h20, SZ_W, 32'h0, 32'h0, 1'b0);
        access("lw_10_cleared", 1'b0, 32'h10, SZ_W, 32'h0, 32'h0, 1'b0);
        access("lw_fc_cleared", 1'b0, 32'hFC, SZ_W, 32'h0, 32'h0, 1'b0);

        z_access("ws0_sw_04",  1'b1, 32'h4, SZ_W,  32'hDEADBEEF, 32'h0);
        z_access("ws0_lhu_06", 1'b0, 32'h6, SZ_HU, 32'h0,        32'h0000DEAD);
        z_access("ws0_lb_04",  1'b0, 32'h4, SZ_B,  32'h0,        32'hFFFFFFEF);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
